lsu_responder: RTL and testbench

//   Data-side responder for the pipelined core's MEM stage. Accepts one load or store per cycle and serves it from
//   on-chip data memory or from the memory-mapped I/O registers (LEDR, LEDG, HEX0-7, LCD, SW).

---
 rtl/lsu_responder.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_lsu_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_responder.sv
`default_nettype none
// ============================================================================
// Module   : lsu_responder
// Purpose  : Data-side responder for the MEM stage of the pipelined core.
//            Serves one load or store per cycle from on-chip data memory or
//            from the memory-mapped I/O registers (LEDR, LEDG, HEX0-7, LCD,
//            SW). Load data returns registered one cycle after the request.
// Ports    : i_clk / i_reset        clock, synchronous active-high reset
//            i_lsu_addr/i_st_data   request byte address, right-aligned store data
//            i_lsu_wren/i_lsu_ren   store / load request strobes
//            i_funct3               access size and sign/zero extension
//            o_ld_data/o_ld_vld     extended load result and its valid pulse
//            o_misaligned           pulse: an illegally aligned request was dropped
//            o_io_*                 registered I/O outputs
//            i_io_sw                asynchronous switch inputs
// Revision : 1.0  initial release
// ============================================================================
module lsu_responder #(
   parameter int DMEM_WORDS     = 2048,
   parameter int SW_SYNC_STAGES = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_lsu_addr,
   input  logic [31:0] i_st_data,
   input  logic        i_lsu_wren,
   input  logic        i_lsu_ren,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_ld_data,
   output logic        o_ld_vld,
   output logic        o_misaligned,
   output logic [31:0] o_io_ledr,
   output logic [31:0] o_io_ledg,
   output logic [6:0]  o_io_hex0,
   output logic [6:0]  o_io_hex1,
   output logic [6:0]  o_io_hex2,
   output logic [6:0]  o_io_hex3,
   output logic [6:0]  o_io_hex4,
   output logic [6:0]  o_io_hex5,
   output logic [6:0]  o_io_hex6,
   output logic [6:0]  o_io_hex7,
   output logic [31:0] o_io_lcd,
   input  logic [31:0] i_io_sw
);

   localparam int c_ADDR_W = $clog2(DMEM_WORDS);

   localparam logic [31:0] c_ADDR_LEDR  = 32'h1000_0000;
   localparam logic [31:0] c_ADDR_LEDG  = 32'h1000_1000;
   localparam logic [31:0] c_ADDR_HEX03 = 32'h1000_2000;
   localparam logic [31:0] c_ADDR_HEX47 = 32'h1000_3000;
   localparam logic [31:0] c_ADDR_LCD   = 32'h1000_4000;
   localparam logic [31:0] c_ADDR_SW    = 32'h1001_0000;

   localparam logic [1:0] c_SZ_B = 2'd0;
   localparam logic [1:0] c_SZ_H = 2'd1;
   localparam logic [1:0] c_SZ_W = 2'd2;

   // ------------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------------
   logic [1:0]          w_size;
   logic                w_unsigned;
   logic                w_misalign;
   logic                w_store;
   logic                w_load;
   logic                w_misal_evt;
   logic [3:0]          w_be;
   logic [31:0]         w_wdata;
   logic [c_ADDR_W-1:0] w_idx;

   logic w_hit_dmem, w_hit_ledr, w_hit_ledg, w_hit_hex03, w_hit_hex47;
   logic w_hit_lcd, w_hit_sw;

   // Stores only look at funct3[1:0]; loads use the full code, and every
   // code that is not a byte or half access is handled as a word.
   always_comb begin
      w_size = c_SZ_W;
      if (i_lsu_wren) begin
         case (i_funct3[1:0])
            2'b00:   w_size = c_SZ_B;
            2'b01:   w_size = c_SZ_H;
            default: w_size = c_SZ_W;
         endcase
      end else begin
         case (i_funct3)
            3'b000, 3'b100: w_size = c_SZ_B;
            3'b001, 3'b101: w_size = c_SZ_H;
            default:        w_size = c_SZ_W;
         endcase
      end
   end

   assign w_unsigned = (i_funct3 == 3'b100) || (i_funct3 == 3'b101);

   assign w_misalign = ((w_size == c_SZ_H) && i_lsu_addr[0]) ||
                       ((w_size == c_SZ_W) && (i_lsu_addr[1:0] != 2'b00));

   // A simultaneous load is dropped in favour of the store.
   assign w_store     = !i_reset && i_lsu_wren && !w_misalign;
   assign w_load      = !i_reset && i_lsu_ren && !i_lsu_wren && !w_misalign;
   assign w_misal_evt = !i_reset && (i_lsu_wren || i_lsu_ren) && w_misalign;

   assign w_idx       = i_lsu_addr[c_ADDR_W+1:2];
   assign w_hit_dmem  = (i_lsu_addr[31:c_ADDR_W+2] == '0);
   assign w_hit_ledr  = (i_lsu_addr[31:2] == c_ADDR_LEDR[31:2]);
   assign w_hit_ledg  = (i_lsu_addr[31:2] == c_ADDR_LEDG[31:2]);
   assign w_hit_hex03 = (i_lsu_addr[31:2] == c_ADDR_HEX03[31:2]);
   assign w_hit_hex47 = (i_lsu_addr[31:2] == c_ADDR_HEX47[31:2]);
   assign w_hit_lcd   = (i_lsu_addr[31:2] == c_ADDR_LCD[31:2]);
   assign w_hit_sw    = (i_lsu_addr[31:2] == c_ADDR_SW[31:2]);

   // Store data is replicated across the word so that every lane enabled by
   // w_be sees the right-aligned byte/half.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_st_data;
      case (w_size)
         c_SZ_B: begin
            w_be    = 4'b0001 << i_lsu_addr[1:0];
            w_wdata = {4{i_st_data[7:0]}};
         end
         c_SZ_H: begin
            w_be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_st_data[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = i_st_data;
         end
      endcase
   end

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

   // ------------------------------------------------------------------------
   // Data memory: synchronous-read RAM with byte enables. The read register
   // only updates on DMEM loads so the load result holds between loads.
   // ------------------------------------------------------------------------
   logic [31:0] mem_q [DMEM_WORDS];
   logic [31:0] mem_rd_q;

   always_ff @(posedge i_clk) begin
      if (w_store && w_hit_dmem) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               mem_q[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
         end
      end
      if (w_load && w_hit_dmem) begin
         mem_rd_q <= mem_q[w_idx];
      end
   end

   // ------------------------------------------------------------------------
   // Switch synchronizer
   // ------------------------------------------------------------------------
   logic [31:0] sw_sync_q [SW_SYNC_STAGES];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int s = 0; s < SW_SYNC_STAGES; s++) begin
            sw_sync_q[s] <= '0;
         end
      end else begin
         sw_sync_q[0] <= i_io_sw;
         for (int s = 1; s < SW_SYNC_STAGES; s++) begin
            sw_sync_q[s] <= sw_sync_q[s-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // I/O output registers
   // ------------------------------------------------------------------------
   logic [31:0] ledr_q;
   logic [31:0] ledg_q;
   logic [31:0] lcd_q;
   logic [6:0]  hex_q [8];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ledr_q <= '0;
         ledg_q <= '0;
         lcd_q  <= '0;
         for (int k = 0; k < 8; k++) begin
            hex_q[k] <= 7'h7F;
         end
      end else if (w_store) begin
         if (w_hit_ledr) ledr_q <= merge_bytes(ledr_q, w_wdata, w_be);
         if (w_hit_ledg) ledg_q <= merge_bytes(ledg_q, w_wdata, w_be);
         if (w_hit_lcd)  lcd_q  <= merge_bytes(lcd_q,  w_wdata, w_be);
         // Each HEX digit owns one byte lane; bit 7 of the lane is dropped.
         for (int b = 0; b < 4; b++) begin
            if (w_hit_hex03 && w_be[b]) hex_q[b]   <= w_wdata[8*b +: 7];
            if (w_hit_hex47 && w_be[b]) hex_q[b+4] <= w_wdata[8*b +: 7];
         end
      end
   end

   assign o_io_ledr = ledr_q;
   assign o_io_ledg = ledg_q;
   assign o_io_lcd  = lcd_q;
   assign o_io_hex0 = hex_q[0];
   assign o_io_hex1 = hex_q[1];
   assign o_io_hex2 = hex_q[2];
   assign o_io_hex3 = hex_q[3];
   assign o_io_hex4 = hex_q[4];
   assign o_io_hex5 = hex_q[5];
   assign o_io_hex6 = hex_q[6];
   assign o_io_hex7 = hex_q[7];

   // I/O read mux; unmapped addresses read as zero.
   logic [31:0] w_io_rdata;

   always_comb begin
      w_io_rdata = '0;
      if (w_hit_ledr) begin
         w_io_rdata = ledr_q;
      end else if (w_hit_ledg) begin
         w_io_rdata = ledg_q;
      end else if (w_hit_lcd) begin
         w_io_rdata = lcd_q;
      end else if (w_hit_hex03) begin
         w_io_rdata = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
      end else if (w_hit_hex47) begin
         w_io_rdata = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
      end else if (w_hit_sw) begin
         w_io_rdata = sw_sync_q[SW_SYNC_STAGES-1];
      end
   end

   // ------------------------------------------------------------------------
   // Load response registers. Lane/extension controls are captured with the
   // request so the output is shaped purely from registered state.
   // ------------------------------------------------------------------------
   logic        ld_vld_q;
   logic        misal_q;
   logic        ld_dmem_q;
   logic [31:0] io_rd_q;
   logic [1:0]  ld_size_q;
   logic        ld_uns_q;
   logic [1:0]  ld_off_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ld_vld_q  <= 1'b0;
         misal_q   <= 1'b0;
         ld_dmem_q <= 1'b0;
         io_rd_q   <= '0;
         ld_size_q <= c_SZ_W;
         ld_uns_q  <= 1'b0;
         ld_off_q  <= 2'b00;
      end else begin
         ld_vld_q <= w_load;
         misal_q  <= w_misal_evt;
         if (w_load) begin
            ld_dmem_q <= w_hit_dmem;
            io_rd_q   <= w_io_rdata;
            ld_size_q <= w_size;
            ld_uns_q  <= w_unsigned;
            ld_off_q  <= i_lsu_addr[1:0];
         end
      end
   end

   logic [31:0] w_word;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_word    = ld_dmem_q ? mem_rd_q : io_rd_q;
      w_byte    = w_word[{ld_off_q, 3'b000} +: 8];
      w_half    = ld_off_q[1] ? w_word[31:16] : w_word[15:0];
      o_ld_data = w_word;
      case (ld_size_q)
         c_SZ_B:  o_ld_data = ld_uns_q ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         c_SZ_H:  o_ld_data = ld_uns_q ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         default: o_ld_data = w_word;
      endcase
   end

   assign o_ld_vld     = ld_vld_q;
   assign o_misaligned = misal_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_responder
// Purpose  : Self-checking bench for lsu_responder. Load expectations are
//            queued when a load is issued and compared when o_ld_vld pulses;
//            I/O, alignment and hold behaviour are checked inline per test.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] st_data;
   logic        wren;
   logic        ren;
   logic [2:0]  f3;
   logic [31:0] sw;
   logic [31:0] ld_data;
   logic        ld_vld;
   logic        misal;
   logic [31:0] ledr, ledg, lcd;
   logic [6:0]  hex [8];

   int          vectors = 0;
   int          errors  = 0;
   logic [31:0] exp_q [$];
   bit          mon_en  = 1'b0;

   always #5 clk = ~clk;

   lsu_responder dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_lsu_addr   (addr),
      .i_st_data    (st_data),
      .i_lsu_wren   (wren),
      .i_lsu_ren    (ren),
      .i_funct3     (f3),
      .o_ld_data    (ld_data),
      .o_ld_vld     (ld_vld),
      .o_misaligned (misal),
      .o_io_ledr    (ledr),
      .o_io_ledg    (ledg),
      .o_io_hex0    (hex[0]),
      .o_io_hex1    (hex[1]),
      .o_io_hex2    (hex[2]),
      .o_io_hex3    (hex[3]),
      .o_io_hex4    (hex[4]),
      .o_io_hex5    (hex[5]),
      .o_io_hex6    (hex[6]),
      .o_io_hex7    (hex[7]),
      .o_io_lcd     (lcd),
      .i_io_sw      (sw)
   );

   // Scoreboard side: every load result pulse is matched to the oldest
   // queued expectation.
   always @(negedge clk) begin
      if (mon_en && ld_vld === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ld_vld_unexpected got=1 exp=0 data=%h t=%0t", ld_data, $time);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (ld_data !== e) begin
               errors++;
               $display("FAIL ld_data got=%h exp=%h t=%0t", ld_data, e, $time);
            end
         end
      end
   end

   // ---------------- stimulus primitives (no checking) ----------------
   task automatic drive(input logic we, input logic re, input logic [31:0] a,
                        input logic [2:0] f, input logic [31:0] d);
      wren = we; ren = re; addr = a; f3 = f; st_data = d;
      @(negedge clk);
      wren = 1'b0; ren = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
      drive(1'b1, 1'b0, a, f, d);
   endtask

   task automatic load(input logic [31:0] a, input logic [2:0] f, input logic [31:0] e);
      exp_q.push_back(e);
      drive(1'b0, 1'b1, a, f, 32'h0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] f);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> (8 * off));
      h = off[1] ? w[31:16] : w[15:0];
      case (f)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      bit hex_ok;
      rst = 1'b1;
      // A request during reset must be dropped.
      drive(1'b1, 1'b0, 32'h1000_0000, 3'b010, 32'hFFFF_FFFF);
      rst = 1'b0;
      vectors++; if (ledr !== 32'h0) begin errors++; $display("FAIL reset_ledr got=%h exp=%h", ledr, 32'h0); end
      vectors++; if (ledg !== 32'h0) begin errors++; $display("FAIL reset_ledg got=%h exp=%h", ledg, 32'h0); end
      vectors++; if (lcd  !== 32'h0) begin errors++; $display("FAIL reset_lcd got=%h exp=%h", lcd, 32'h0); end
      hex_ok = 1'b1;
      for (int k = 0; k < 8; k++) if (hex[k] !== 7'h7F) hex_ok = 1'b0;
      vectors++; if (!hex_ok) begin errors++; $display("FAIL reset_hex got=%h%h%h%h exp=7f each", hex[3], hex[2], hex[1], hex[0]); end
      vectors++; if (ld_vld !== 1'b0) begin errors++; $display("FAIL reset_ld_vld got=%b exp=0", ld_vld); end
      vectors++; if (misal !== 1'b0) begin errors++; $display("FAIL reset_misal got=%b exp=0", misal); end
      vectors++; if (ld_data !== 32'h0) begin errors++; $display("FAIL reset_ld_data got=%h exp=%h", ld_data, 32'h0); end
      mon_en = 1'b1;
   endtask

   task automatic test_dmem_ext();
      store(32'h10, 3'b010, 32'h1234_ABCD);
      load(32'h13, 3'b000, 32'h0000_0012);
      load(32'h13, 3'b100, 32'h0000_0012);
      load(32'h12, 3'b001, 32'h0000_1234);
      load(32'h12, 3'b101, 32'h0000_1234);
      load(32'h10, 3'b000, 32'hFFFF_FFCD);
      load(32'h10, 3'b001, 32'hFFFF_ABCD);
      load(32'h10, 3'b101, 32'h0000_ABCD);
      load(32'h11, 3'b100, 32'h0000_00AB);
      load(32'h10, 3'b010, 32'h1234_ABCD);
      load(32'h10, 3'b111, 32'h1234_ABCD);
      idle(1);
   endtask

   task automatic test_io();
      store(32'h1000_2001, 3'b000, 32'h0000_003F);
      vectors++; if (hex[1] !== 7'h3F) begin errors++; $display("FAIL hex1 got=%h exp=%h", hex[1], 7'h3F); end
      vectors++; if ({hex[0], hex[2], hex[3]} !== {3{7'h7F}}) begin
         errors++; $display("FAIL hex023 got=%h/%h/%h exp=7f/7f/7f", hex[0], hex[2], hex[3]); end
      load(32'h1000_2000, 3'b010, 32'h7F7F_3F7F);
      store(32'h1000_3000, 3'b010, 32'h8182_0304);
      vectors++; if ({hex[7], hex[6], hex[5], hex[4]} !== {7'h01, 7'h02, 7'h03, 7'h04}) begin
         errors++; $display("FAIL hex4567 got=%h/%h/%h/%h exp=01/02/03/04", hex[7], hex[6], hex[5], hex[4]); end
      load(32'h1000_3000, 3'b010, 32'h0102_0304);
      store(32'h1000_0000, 3'b010, 32'hCAFE_F00D);
      vectors++; if (ledr !== 32'hCAFE_F00D) begin errors++; $display("FAIL ledr got=%h exp=%h", ledr, 32'hCAFE_F00D); end
      store(32'h1000_1002, 3'b001, 32'h1234_BEEF);
      vectors++; if (ledg !== 32'hBEEF_0000) begin errors++; $display("FAIL ledg got=%h exp=%h", ledg, 32'hBEEF_0000); end
      store(32'h1000_4003, 3'b000, 32'h0000_005A);
      vectors++; if (lcd !== 32'h5A00_0000) begin errors++; $display("FAIL lcd got=%h exp=%h", lcd, 32'h5A00_0000); end
      load(32'h1000_0002, 3'b001, 32'hFFFF_CAFE);
      load(32'h1000_4000, 3'b010, 32'h5A00_0000);
      idle(1);
   endtask

   task automatic test_misaligned();
      drive(1'b0, 1'b1, 32'h0000_0002, 3'b010, 32'h0);
      vectors++; if (misal !== 1'b1) begin errors++; $display("FAIL misal_lw got=%b exp=1", misal); end
      vectors++; if (ld_vld !== 1'b0) begin errors++; $display("FAIL misal_lw_vld got=%b exp=0", ld_vld); end
      store(32'h0000_0011, 3'b001, 32'h0000_FFFF);
      vectors++; if (misal !== 1'b1) begin errors++; $display("FAIL misal_sh got=%b exp=1", misal); end
      idle(1);
      vectors++; if (misal !== 1'b0) begin errors++; $display("FAIL misal_pulse got=%b exp=0", misal); end
      load(32'h10, 3'b010, 32'h1234_ABCD);
      idle(1);
   endtask

   task automatic test_sw();
      // Loads sampled at edges 1, 2 and 3 after the change: two stages of delay.
      sw = 32'hA5A5_0001;
      load(32'h1001_0000, 3'b010, 32'h0);
      load(32'h1001_0000, 3'b010, 32'h0);
      load(32'h1001_0000, 3'b010, 32'hA5A5_0001);
      store(32'h1001_0000, 3'b010, 32'h0);
      load(32'h1001_0000, 3'b010, 32'hA5A5_0001);
      load(32'h2000_0000, 3'b010, 32'h0);
      store(32'h2000_0004, 3'b010, 32'hFFFF_FFFF);
      load(32'h2000_0004, 3'b010, 32'h0);
      // First address past the end of DMEM is unmapped.
      load(32'h0000_2000, 3'b010, 32'h0);
      idle(1);
   endtask

   task automatic test_back_to_back();
      store(32'h40, 3'b010, 32'hDEAD_BEEF);
      load(32'h40, 3'b010, 32'hDEAD_BEEF);
      store(32'h1000_0000, 3'b010, 32'h0);
      idle(2);
      vectors++; if (ld_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_hold got=%h exp=%h", ld_data, 32'hDEAD_BEEF); end
      drive(1'b1, 1'b1, 32'h44, 3'b010, 32'h1122_3344);
      vectors++; if (ld_vld !== 1'b0) begin errors++; $display("FAIL wren_ren_vld got=%b exp=0", ld_vld); end
      load(32'h44, 3'b010, 32'h1122_3344);
      idle(1);
   endtask

   task automatic test_random();
      logic [31:0] mdl [32];
      logic [31:0] base;
      base = 32'h400;
      for (int i = 0; i < 32; i++) begin
         mdl[i] = $urandom;
         store(base + 32'(4 * i), 3'b010, mdl[i]);
      end
      for (int n = 0; n < 80; n++) begin
         int          i;
         logic [1:0]  off;
         logic [2:0]  f;
         logic [31:0] d;
         i = $urandom_range(31);
         off = 2'($urandom_range(3));
         d = $urandom;
         if ($urandom_range(2) == 0) begin
            f = 3'($urandom_range(2));
            if (f == 3'b001) off[0] = 1'b0;
            if (f == 3'b010) off = 2'b00;
            case (f)
               3'b000:  mdl[i][8*off +: 8]  = d[7:0];
               3'b001:  mdl[i][8*off +: 16] = d[15:0];
               default: mdl[i] = d;
            endcase
            store(base + 32'(4 * i) + 32'(off), f, d);
         end else begin
            case ($urandom_range(7))
               0: f = 3'b000;  1: f = 3'b001;  2: f = 3'b010;  3: f = 3'b011;
               4: f = 3'b100;  5: f = 3'b101;  6: f = 3'b110;  default: f = 3'b111;
            endcase
            if (f == 3'b001 || f == 3'b101) off[0] = 1'b0;
            else if (f != 3'b000 && f != 3'b100) off = 2'b00;
            load(base + 32'(4 * i) + 32'(off), f, ref_load(mdl[i], off, f));
         end
      end
      idle(1);
   endtask

   initial begin
      rst = 1'b1; addr = '0; st_data = '0; wren = 1'b0; ren = 1'b0; f3 = '0; sw = '0;
      test_reset();
      test_dmem_ext();
      test_io();
      test_misaligned();
      test_sw();
      test_back_to_back();
      test_random();
      idle(2);
      vectors++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_loads got=%0d exp=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
